// File: rtl/hsv_core_pkg.sv
// hsv_core_pkg: decoded-instruction types and unit count shared by issue and commit.
package hsv_core_pkg;
  localparam int NUM_UNITS = 5;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    logic [4:0] rd_addr;
    logic       writes_rd;
  } common_data_t;
  // Packed MSB-first, so alu lands on bit 0 of the dispatch vector.
  typedef struct packed {
    logic ctrlstatus;
    logic branch;
    logic mem;
    logic foo;
    logic alu;
  } exec_select_t;
  typedef struct packed {
    logic       illegal;
    logic [3:0] op;
  } alu_data_t;
  typedef struct packed {
    common_data_t common;
    exec_select_t exec_select;
    alu_data_t    alu_data;
    logic [31:0]  imm;
  } issue_data_t;
endpackage

// File: rtl/hsv_core_issue_scoreboard.sv
// hsv_core_issue_scoreboard: pending-writeback vector with RAW/WAW hazard detection.
module hsv_core_issue_scoreboard
  import hsv_core_pkg::*;
(
  input  logic                clk_core,
  input  logic                rst_core_n,
  input  logic                flush,
  input  logic                valid,
  input  common_data_t        common,
  input  logic                set_en,
  input  logic                wb_valid_i,
  input  logic [4:0]          wb_rd_i,
  output logic                hazard,
  output logic [NUM_REGS-1:0] pending
);
  logic [NUM_REGS-1:0] set_mask, clr_mask, pend_chk;
  logic [NUM_REGS-1:1] pend_q;
  assign set_mask = set_en & common.writes_rd ? NUM_REGS'(1) << common.rd_addr : '0;
  assign clr_mask = wb_valid_i ? NUM_REGS'(1) << wb_rd_i : '0;
  assign pending = {pend_q, 1'b0};
`ifdef HSV_ISSUE_BYPASS_EN
  assign pend_chk = pending & ~clr_mask;
`else
  assign pend_chk = pending;
`endif
  assign hazard = valid & (pend_chk[common.rs1_addr] | pend_chk[common.rs2_addr] |
                           (common.writes_rd & pend_chk[common.rd_addr]));
  // Set is OR-ed after the clear so a same-cycle set wins; x0 never stored.
  always_ff @(posedge clk_core or negedge rst_core_n)
    if (!rst_core_n) pend_q <= '0;
    else pend_q <= flush ? '0 : (pend_q & ~clr_mask[NUM_REGS-1:1]) | set_mask[NUM_REGS-1:1];
endmodule

// File: rtl/hsv_core_issue.sv
// hsv_core_issue: scoreboarded single-slot issue stage with flush handshake.
// Optional HSV_ISSUE_BYPASS_EN lets an instruction issue in its operand's writeback cycle.
module hsv_core_issue
  import hsv_core_pkg::*;
(
  input  logic                 clk_core,
  input  logic                 rst_core_n,
  input  logic                 flush_req,
  output logic                 flush_ack,
  output logic                 ready_o,
  input  logic                 valid_i,
  input  issue_data_t          issue_data,
  output logic [4:0]           rf_rs1_addr_o,
  output logic [4:0]           rf_rs2_addr_o,
  input  logic [31:0]          rf_rs1_data_i,
  input  logic [31:0]          rf_rs2_data_i,
  input  logic                 wb_valid_i,
  input  logic [4:0]           wb_rd_i,
  output logic [NUM_UNITS-1:0] dispatch_valid_o,
  input  logic [NUM_UNITS-1:0] dispatch_ready_i,
  output issue_data_t          dispatch_data_o,
  output logic [31:0]          rs1_value_o,
  output logic [31:0]          rs2_value_o
);
  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;
  logic [0:0] state;
  logic out_valid, hazard, slot_free, flush_active, accept, set_en;
  issue_data_t out_data;
  logic [31:0] rs1_q, rs2_q;
  logic [NUM_REGS-1:0] pending;
  assign rf_rs1_addr_o = issue_data.common.rs1_addr;
  assign rf_rs2_addr_o = issue_data.common.rs2_addr;
  // The cycle after flush_req drops is still FLUSH, so it blocks accepts too.
  assign flush_active = flush_req | (state == ST_FLUSH);
  assign dispatch_valid_o = out_valid ? out_data.exec_select : '0;
  assign slot_free = ~out_valid | (|(dispatch_valid_o & dispatch_ready_i));
  assign ready_o = ~hazard & slot_free & ~flush_active;
  assign accept = valid_i & ready_o;
  assign set_en = accept & ~(issue_data.exec_select.alu & issue_data.alu_data.illegal);
  assign dispatch_data_o = out_data;
  assign rs1_value_o = rs1_q;
  assign rs2_value_o = rs2_q;
  hsv_core_issue_scoreboard u_scoreboard (
    .clk_core  (clk_core),
    .rst_core_n(rst_core_n),
    .flush     (flush_active),
    .valid     (valid_i),
    .common    (issue_data.common),
    .set_en    (set_en),
    .wb_valid_i(wb_valid_i),
    .wb_rd_i   (wb_rd_i),
    .hazard    (hazard),
    .pending   (pending)
  );
  always_ff @(posedge clk_core or negedge rst_core_n)
    if (!rst_core_n) begin
      state <= ST_RUN;
      flush_ack <= 1'b1;
    end else begin
      state <= flush_req ? ST_FLUSH : ST_RUN;
      flush_ack <= flush_req;
    end
  always_ff @(posedge clk_core or negedge rst_core_n)
    if (!rst_core_n) out_valid <= 1'b0;
    else out_valid <= ~flush_active & (accept | ~slot_free);
  always_ff @(posedge clk_core or negedge rst_core_n)
    if (!rst_core_n) begin
      out_data <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
    end else if (accept) begin
      out_data <= issue_data;
      rs1_q <= rf_rs1_data_i;
      rs2_q <= rf_rs2_data_i;
    end
endmodule

// File: tb/tb_hsv_core_issue.sv
// tb_hsv_core_issue: directed scenarios plus random traffic against a behavioural issue model.
module tb_hsv_core_issue;
  import hsv_core_pkg::*;
  logic clk_core = 1'b0;
  logic rst_core_n = 1'b0;
  logic flush_req = 1'b0, flush_ack, ready_o, valid_i = 1'b0;
  issue_data_t issue_data = '0;
  logic [4:0] rf_rs1_addr_o, rf_rs2_addr_o;
  logic [31:0] rf_rs1_data_i = '0, rf_rs2_data_i = '0;
  logic wb_valid_i = 1'b0;
  logic [4:0] wb_rd_i = '0;
  logic [4:0] dispatch_valid_o;
  logic [4:0] dispatch_ready_i = 5'h1f;
  issue_data_t dispatch_data_o;
  logic [31:0] rs1_value_o, rs2_value_o;
  int n_checks = 0, n_errs = 0;
  // Reference model state: which registers await writeback, the held slot, flush history.
  logic [31:0] m_pend;
  bit m_held, m_flush_prev, m_ack;
  issue_data_t m_out;
  logic [31:0] m_v1, m_v2;

  hsv_core_issue dut (
    .clk_core(clk_core), .rst_core_n(rst_core_n), .flush_req(flush_req), .flush_ack(flush_ack),
    .ready_o(ready_o), .valid_i(valid_i), .issue_data(issue_data),
    .rf_rs1_addr_o(rf_rs1_addr_o), .rf_rs2_addr_o(rf_rs2_addr_o),
    .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
    .dispatch_valid_o(dispatch_valid_o), .dispatch_ready_i(dispatch_ready_i),
    .dispatch_data_o(dispatch_data_o), .rs1_value_o(rs1_value_o), .rs2_value_o(rs2_value_o)
  );

  always #5 clk_core = ~clk_core;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_held = 0;
    m_flush_prev = 0;
    m_ack = 1;
    m_out = '0;
    m_v1 = '0;
    m_v2 = '0;
  endtask

  task automatic set_op(input int rs1, input int rs2, input int rd, input bit wr, input int unit,
                        input bit illegal);
    issue_data = '0;
    issue_data.common.rs1_addr = 5'(rs1);
    issue_data.common.rs2_addr = 5'(rs2);
    issue_data.common.rd_addr = 5'(rd);
    issue_data.common.writes_rd = wr;
    issue_data.exec_select = exec_select_t'(5'(1) << unit);
    issue_data.alu_data.illegal = illegal;
    issue_data.alu_data.op = 4'($urandom_range(0, 15));
    issue_data.imm = $urandom;
    rf_rs1_data_i = $urandom;
    rf_rs2_data_i = $urandom;
  endtask

  // Inputs are driven just after a rising edge; step checks mid-cycle, then advances the model.
  task automatic step();
    logic [31:0] busy;
    logic [4:0] dv;
    bit blocked, haz, fire, rdy, acc, sets;
    int rs1, rs2, rd;
    #3;
    rs1 = int'(issue_data.common.rs1_addr);
    rs2 = int'(issue_data.common.rs2_addr);
    rd = int'(issue_data.common.rd_addr);
    blocked = flush_req || m_flush_prev;
    busy = m_pend;
`ifdef HSV_ISSUE_BYPASS_EN
    if (wb_valid_i) busy[wb_rd_i] = 1'b0;
`endif
    haz = valid_i && (busy[rs1] || busy[rs2] || (issue_data.common.writes_rd && busy[rd]));
    dv = m_held ? 5'(m_out.exec_select) : 5'b0;
    fire = (dv & dispatch_ready_i) != 0;
    rdy = !haz && (!m_held || fire) && !blocked;
    acc = valid_i && rdy;
    check("ready", 64'(ready_o), 64'(rdy));
    check("dispatch_valid", 64'(dispatch_valid_o), 64'(dv));
    check("flush_ack", 64'(flush_ack), 64'(m_ack));
    check("pending", 64'(dut.u_scoreboard.pending), 64'(m_pend));
    check("rf_addrs", 64'({rf_rs1_addr_o, rf_rs2_addr_o}), 64'({5'(rs1), 5'(rs2)}));
    if (m_held) begin
      check("dispatch_data", 64'(dispatch_data_o), 64'(m_out));
      check("operands", {rs1_value_o, rs2_value_o}, {m_v1, m_v2});
    end
    @(posedge clk_core);
    if (blocked) begin
      m_pend = '0;
      m_held = 0;
    end else begin
      if (wb_valid_i) m_pend[wb_rd_i] = 1'b0;
      sets = acc && issue_data.common.writes_rd && rd != 0 &&
             !(issue_data.exec_select.alu && issue_data.alu_data.illegal);
      if (sets) m_pend[rd] = 1'b1;
      if (acc) begin
        m_held = 1;
        m_out = issue_data;
        m_v1 = rf_rs1_data_i;
        m_v2 = rf_rs2_data_i;
      end else if (fire) m_held = 0;
    end
    m_flush_prev = flush_req;
    m_ack = flush_req;
    #1;
  endtask

  task automatic idle();
    valid_i = 0;
    wb_valid_i = 0;
    flush_req = 0;
    dispatch_ready_i = 5'h1f;
  endtask

  initial begin
    model_reset();
    #12;
    check("reset_ready", 64'(ready_o), 64'(1));
    check("reset_dvalid", 64'(dispatch_valid_o), 64'(0));
    check("reset_ack", 64'(flush_ack), 64'(1));
    @(posedge clk_core);
    #1 rst_core_n = 1;
    // Independent back-to-back ALU ops.
    set_op(2, 3, 1, 1, 0, 0); valid_i = 1; step();
    set_op(5, 6, 4, 1, 0, 0); step();
    idle(); step();
    check("b2b_pending", 64'(dut.u_scoreboard.pending), 64'h12);
    step();
    // RAW on x1 released by writeback of x1 (x4 also still pending).
    set_op(1, 1, 7, 1, 0, 0); valid_i = 1; step();
    wb_valid_i = 1; wb_rd_i = 1;
`ifdef HSV_ISSUE_BYPASS_EN
    #3 check("raw_wb_cycle_ready", 64'(ready_o), 64'(1));
`else
    #3 check("raw_wb_cycle_ready", 64'(ready_o), 64'(0));
`endif
    #0 step();
    wb_valid_i = 0; step();
    idle(); wb_valid_i = 1; wb_rd_i = 7; step();
    wb_rd_i = 4; step();
    idle(); step();
    // Backpressure on a mem op.
    set_op(8, 9, 10, 1, 2, 0); valid_i = 1; dispatch_ready_i = 5'b11011; step();
    set_op(11, 12, 13, 1, 0, 0);
    repeat (3) step();
    check("bp_held", 64'(dispatch_valid_o), 64'(5'b00100));
    dispatch_ready_i = 5'h1f; step();
    idle(); step(); step();
    wb_valid_i = 1; wb_rd_i = 10; step();
    wb_rd_i = 13; step();
    // Same-cycle set and clear of x5.
    idle(); set_op(0, 0, 5, 1, 0, 0); valid_i = 1; wb_valid_i = 1; wb_rd_i = 5; step();
    idle(); step();
    check("set_wins", 64'(dut.u_scoreboard.pending[5]), 64'(1));
    wb_valid_i = 1; wb_rd_i = 5; step();
    // Flush with x3 pending and output held, then an x0 writer.
    idle(); set_op(1, 2, 3, 1, 2, 0); valid_i = 1; dispatch_ready_i = 5'b0; step();
    valid_i = 0; step();
    flush_req = 1; step();
    flush_req = 0;
    check("flush_dvalid", 64'(dispatch_valid_o), 64'(0));
    check("flush_pending", 64'(dut.u_scoreboard.pending), 64'(0));
    check("flush_ack_hi", 64'(flush_ack), 64'(1));
    step();
    dispatch_ready_i = 5'h1f; set_op(1, 2, 0, 1, 0, 0); valid_i = 1; step();
    idle(); step();
    check("x0_never_pending", 64'(dut.u_scoreboard.pending[0]), 64'(0));
    // Random traffic over a small register window to provoke hazards.
    for (int i = 0; i < 500; i++) begin
      set_op($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
             $urandom_range(0, 4), $urandom_range(0, 7) == 0);
      valid_i = $urandom_range(0, 9) < 7;
      wb_valid_i = $urandom_range(0, 9) < 3;
      wb_rd_i = 5'($urandom_range(0, 7));
      dispatch_ready_i = 5'($urandom);
      flush_req = $urandom_range(0, 19) == 0;
      step();
    end
    // Reset while a mem op is stalled drops it without a handshake.
    idle(); step(); step();
    set_op(1, 2, 6, 1, 2, 0); valid_i = 1; dispatch_ready_i = 5'b0; step();
    valid_i = 0; step();
    #2 rst_core_n = 0;
    #1 check("rst_stall_dvalid", 64'(dispatch_valid_o), 64'(0));
    check("rst_stall_pending", 64'(dut.u_scoreboard.pending), 64'(0));
    model_reset();
    @(posedge clk_core);
    #1 rst_core_n = 1;
    idle(); step(); step();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
